// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event scheduler.
// Holds the button count, event type encodings and per-button FSM state
// encodings used by btn_hold_fsm and btn_event_sched.
package btn_evt_pkg;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned ID_W    = 2;

  localparam logic EVT_PRESS  = 1'b0;
  localparam logic EVT_REPEAT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RPT  = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_hold_fsm.sv
// Per-button press / auto-repeat state machine.
// Emits a one-cycle raise strobe (raise_c) with its event type (raise_type_c)
// for the same clock edge at which the FSM registers the transition.
// Optional feature macro: BTN_REPEAT_EN (hold/repeat counters and REPEAT events).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   btn           current debounced button level
//   rise          rising edge of btn (from the top-level edge detector)
//   raise_c       event raised this cycle (combinational)
//   raise_type_c  0 = PRESS, 1 = REPEAT (combinational)
module btn_hold_fsm
  import btn_evt_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic rise,
  output logic raise_c,
  output logic raise_type_c
);

  btn_state_e state_q, state_d;

`ifdef BTN_REPEAT_EN

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end
      end
      ST_HELD: begin
        if (!btn) begin
          state_d = ST_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RPT: begin
        if (!btn) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raise strobes
  always_comb begin
    raise_c      = 1'b0;
    raise_type_c = EVT_PRESS;
    unique case (state_q)
      ST_IDLE: raise_c = rise;
      ST_HELD: begin
        if (btn && (cnt_q == HOLD_LAST)) begin
          raise_c      = 1'b1;
          raise_type_c = EVT_REPEAT;
        end
      end
      ST_RPT: begin
        if (btn && (cnt_q == RPT_LAST)) begin
          raise_c      = 1'b1;
          raise_type_c = EVT_REPEAT;
        end
      end
      default: ;
    endcase
  end

`else

  // Timing parameters have no effect without the repeat feature
  logic [31:0] unused_cfg;
  assign unused_cfg = HOLD_CYCLES ^ REPEAT_CYCLES ^ CNT_W;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: press tracking only
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (rise) state_d = ST_HELD;
      ST_HELD: if (!btn) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Raise strobes
  always_comb begin
    raise_c      = 1'b0;
    raise_type_c = EVT_PRESS;
    if (state_q == ST_IDLE) raise_c = rise;
  end

`endif

endmodule

// File: rtl/btn_event_sched.sv
// Button event scheduler: converts debounced button levels into PRESS and
// auto-repeat events, keeps one pending event per button, and delivers them
// round-robin to a single consumer over valid/ready.
// Optional feature macro: BTN_REPEAT_EN (REPEAT events; otherwise PRESS only).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   button_in   debounced button levels, bit i = button i
//   evt_valid   event presented
//   evt_ready   consumer accepts the presented event
//   evt_id      button index of the presented event
//   evt_type    0 = PRESS, 1 = REPEAT
//   ovf         sticky per-button overflow (an event was dropped)
//   ovf_clr     clears all ovf bits
module btn_event_sched
  import btn_evt_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] button_in,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_type,
  output logic [NUM_BTN-1:0] ovf,
  input  logic               ovf_clr
);

  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] rise_c;
  logic [NUM_BTN-1:0] raise_c;
  logic [NUM_BTN-1:0] raise_type_c;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [NUM_BTN-1:0] ptype_q, ptype_d;
  logic [NUM_BTN-1:0] ovf_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    cand_c;
  logic [ID_W-1:0]    gnt_idx_c;
  logic               gnt_vld_c;
  logic               load_c;

  assign rise_c = button_in & ~btn_q;
  assign load_c = ~evt_valid | evt_ready;

  // One press/repeat FSM per button
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_hold_fsm #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .btn          (button_in[i]),
      .rise         (rise_c[i]),
      .raise_c      (raise_c[i]),
      .raise_type_c (raise_type_c[i])
    );
  end

  // Round-robin search starting after last_grant; index wraps mod NUM_BTN
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = last_grant_q;
    cand_c    = last_grant_q;
    for (int unsigned k = 1; k <= NUM_BTN; k++) begin
      cand_c = last_grant_q + ID_W'(k);
      if (!gnt_vld_c && pend_q[cand_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = cand_c;
      end
    end
  end

  // Pending slots and overflow: a same-cycle raise overrides the grant clear
  always_comb begin
    pend_d  = pend_q;
    ptype_d = ptype_q;
    ovf_d   = ovf_clr ? '0 : ovf;
    if (load_c && gnt_vld_c) pend_d[gnt_idx_c] = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (raise_c[i]) begin
        if (pend_d[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          ptype_d[i] = raise_type_c[i];
        end
      end
    end
  end

  // Edge detector, slots, overflow and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q        <= '1;
      pend_q       <= '0;
      ptype_q      <= '0;
      ovf          <= '0;
      last_grant_q <= ID_W'(NUM_BTN - 1);
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      evt_type     <= EVT_PRESS;
    end else begin
      btn_q   <= button_in;
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      ovf     <= ovf_d;
      if (load_c) begin
        evt_valid <= gnt_vld_c;
        if (gnt_vld_c) begin
          evt_id       <= gnt_idx_c;
          evt_type     <= ptype_q[gnt_idx_c];
          last_grant_q <= gnt_idx_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_event_sched.sv
// Self-checking bench for btn_event_sched (HOLD_CYCLES=8, REPEAT_CYCLES=4).
// Expected events are queued with their delivery cycle when stimulus is
// driven and compared when the consumer accepts each transfer.
module tb_btn_event_sched;
  import btn_evt_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] button_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_type;
  logic [3:0] ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int id;
    int typ;
    int cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_event_sched #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button_in (button_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input int typ, input int c);
    exp_t e;
    e.id  = id;
    e.typ = typ;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag, input int n);
    step(n);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // Transfer monitor: every accepted event must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      chk("xfer_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("evt_id", 32'(evt_id), 32'(e.id));
        chk("evt_type", 32'(evt_type), 32'(e.typ));
        if (e.cyc >= 0) chk("evt_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    button_in = 4'b0000;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    step(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_type", 32'(evt_type), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step(2);

    // Single press on button 1
    n = cyc;
    button_in = 4'b0010;
    push(1, 0, n + 2);
    step(3);
    button_in = 4'b0000;
    drain("single_drain", 20);

    // Hold button 0 for 20 cycles
    n = cyc;
    button_in = 4'b0001;
    push(0, 0, n + 2);
`ifdef BTN_REPEAT_EN
    push(0, 1, n + 10);
    push(0, 1, n + 14);
    push(0, 1, n + 18);
`endif
    step(20);
    button_in = 4'b0000;
    drain("hold_drain", 15);

    // Round-robin from reset: 0,1,2,3
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    n = cyc;
    button_in = 4'b1111;
    for (int i = 0; i < 4; i++) push(i, 0, n + 2 + i);
    step(3);
    button_in = 4'b0000;
    drain("rr1_drain", 10);

    // Grant to 2, then all rise: order 3,0,1,2
    n = cyc;
    button_in = 4'b0100;
    push(2, 0, n + 2);
    step(2);
    button_in = 4'b0000;
    drain("rr2a_drain", 4);
    n = cyc;
    button_in = 4'b1111;
    for (int i = 0; i < 4; i++) push((3 + i) % 4, 0, n + 2 + i);
    step(3);
    button_in = 4'b0000;
    drain("rr2b_drain", 10);

    // Stall and overflow on button 2
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      button_in = 4'b0100;
      if (p < 2) push(2, 0, -1);
      step(2);
      button_in = 4'b0000;
      step(2);
    end
    chk("ovf_set", 32'(ovf), 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(evt_valid), 32'd1);
      chk("stall_id", 32'(evt_id), 32'd2);
      chk("stall_type", 32'(evt_type), 32'd0);
      step(1);
    end
    evt_ready = 1'b1;
    drain("stall_drain", 6);
    chk("ovf_sticky", 32'(ovf), 32'h4);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'h0);

    // Reset while an event is presented and button 1 held
    evt_ready = 1'b0;
    button_in = 4'b0010;
    step(4);
    chk("pre_rst_valid", 32'(evt_valid), 32'd1);
    chk("pre_rst_id", 32'(evt_id), 32'd1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_id", 32'(evt_id), 32'd0);
    rst = 1'b0;
    evt_ready = 1'b1;
    step(6);
    chk("held_thru_rst_valid", 32'(evt_valid), 32'd0);
    button_in = 4'b0000;
    step(2);
    n = cyc;
    button_in = 4'b0010;
    push(1, 0, n + 2);
    step(3);
    button_in = 4'b0000;
    drain("repress_drain", 10);

    // Long hold on button 3 (single PRESS without repeat feature)
    n = cyc;
    button_in = 4'b1000;
    push(3, 0, n + 2);
`ifdef BTN_REPEAT_EN
    for (int k = 9; k <= 49; k += 4) push(3, 1, n + k + 1);
`endif
    step(50);
    button_in = 4'b0000;
    drain("long_drain", 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
